// File: rtl/down_timer_ctrl.sv
// -----------------------------------------------------------------------------
// down_timer_ctrl
//
// Purpose:
//   Command-driven countdown timer. A host issues LOAD / START / STOP commands
//   over a valid/ready handshake; the block sequences an internal WIDTH-bit
//   down counter through IDLE -> ARMED -> RUN -> DONE. DONE always lasts one
//   cycle and drives a single-cycle expiry pulse. With auto_reload set, DONE
//   reloads the last LOAD value and runs again.
//
// Optional feature:
//   TIMER_PRESCALE_EN - when defined, adds the presc_div port and a prescaler
//   so the counter decrements once every presc_div+1 cycles. When undefined,
//   the counter decrements on every cycle in RUN.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  command can be accepted this cycle (combinational)
//   cmd_op       in   00 NOP, 01 LOAD, 10 START, 11 STOP
//   cmd_data     in   LOAD value
//   auto_reload  in   sampled in DONE: 1 = reload and rerun
//   count        out  current counter value (registered)
//   state        out  00 IDLE, 01 ARMED, 10 RUN, 11 DONE (registered)
//   busy         out  high while in RUN (registered)
//   expired      out  high for the single DONE cycle (registered)
//   presc_div    in   tick divider (TIMER_PRESCALE_EN only)
// -----------------------------------------------------------------------------
module down_timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             expired
`ifdef TIMER_PRESCALE_EN
  ,
  input  logic [PRESCALE_W-1:0] presc_div
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             busy_reg;
  logic             expired_reg;

  logic cmd_acc;
  logic is_load;
  logic is_start;
  logic is_stop;
  logic tick;

  // DONE is a fixed one-cycle state, so no command can be taken there.
  assign cmd_ready = !rst && (state_reg != ST_DONE);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign is_load   = cmd_acc && (cmd_op == OP_LOAD);
  assign is_start  = cmd_acc && (cmd_op == OP_START);
  assign is_stop   = cmd_acc && (cmd_op == OP_STOP);

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_reg;

  assign tick = (presc_reg == presc_div);

  // Counts only while RUN continues; any other situation (entering RUN from
  // ARMED/DONE, STOP, idle states) leaves it at zero so every run starts
  // with a full prescale period.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (state_reg == ST_RUN && !is_stop && !tick) begin
      presc_reg <= presc_reg + 1'b1;
    end else begin
      presc_reg <= '0;
    end
  end
`else
  assign tick = 1'b1;

  // PRESCALE_W only shapes the optional prescaler; this keeps the parameter
  // referenced in builds without it.
  if (PRESCALE_W > 0) begin : g_presc_w_ok
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= ZERO;
      reload_reg  <= ZERO;
      busy_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (is_load) begin
            reload_reg <= cmd_data;
            count_reg  <= cmd_data;
            state_reg  <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (is_load) begin
            reload_reg <= cmd_data;
            count_reg  <= cmd_data;
          end else if (is_start) begin
            if (count_reg != ZERO) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
            end else begin
              state_reg   <= ST_DONE;
              expired_reg <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          // STOP takes priority over the decrement, even a terminal one.
          if (is_stop) begin
            state_reg <= ST_ARMED;
            busy_reg  <= 1'b0;
          end else begin
            // A LOAD while running only retargets the next reload.
            if (is_load) begin
              reload_reg <= cmd_data;
            end
            if (tick) begin
              // <= ONE also covers a zero count so the counter never wraps.
              if (count_reg <= ONE) begin
                count_reg   <= ZERO;
                state_reg   <= ST_DONE;
                busy_reg    <= 1'b0;
                expired_reg <= 1'b1;
              end else begin
                count_reg <= count_reg - ONE;
              end
            end
          end
        end

        ST_DONE: begin
          expired_reg <= 1'b0;
          // A zero reload value would expire immediately forever, so it is
          // treated as one-shot.
          if (auto_reload && (reload_reg != ZERO)) begin
            count_reg <= reload_reg;
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
          end else begin
            count_reg <= ZERO;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          busy_reg    <= 1'b0;
          expired_reg <= 1'b0;
        end
      endcase
    end
  end

  assign count   = count_reg;
  assign state   = state_reg;
  assign busy    = busy_reg;
  assign expired = expired_reg;

endmodule
